mio_bus_arbiter: RTL and testbench
==================================

MIO_BUS_ARBITER -- requirements
Module: mio_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, max ACCESS cycles before forced termination (range 2..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  requester 0 (CPU) transaction request; held until m0_ack.
REQ-005 m0_addr / m0_wdata  input  32 / 32  requester 0 address / write data; stable while m0_req=1.
REQ-006 m0_we  input  1  requester 0 write enable; 0 = read.
REQ-007 m0_rdata  output  32  requester 0 read data; valid in the m0_ack cycle.
REQ-008 m0_ack  output  1  requester 0 completion; one-cycle pulse.
REQ-009 m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_ack  same widths/directions  requester 1 (DMA/VRAM refresh), identical semantics.
REQ-010 bus_addr / bus_wdata  output  32 / 32  shared bus address / write data (feeds the memory/IO decoder).
REQ-011 bus_we  output  1  shared bus write strobe (mem_w).
REQ-012 bus_rdata  input  32  shared bus read data.
REQ-013 bus_ready  input  1  slave completion; 1 = access done this cycle.
REQ-014 owner  output  2  2'b00 none, 2'b01 m0, 2'b10 m1.
REQ-015 err  output  1  timeout flag; pulses with the terminated requester's ack.

Function
REQ-016 FSM states IDLE, ACCESS, ACK; all outputs registered.
REQ-017 IDLE: no req -> stay; any req -> latch winner's addr/wdata/we, set owner, go ACCESS next edge.
REQ-018 Arbitration round-robin: pointer names preferred requester; both requesting -> preferred wins; only one requesting -> it wins.
REQ-019 Pointer moves to the other requester when a transaction enters ACK; unchanged when idle.
REQ-020 ACCESS: bus_addr/bus_wdata from latches; bus_we = latched we; bus_we=0 in every other state.
REQ-021 ACCESS with bus_ready=1: capture bus_rdata into owner's rdata, go ACK.
REQ-022 ACK: owner's ack=1 exactly one cycle; other ack stays 0; bus_we=0; next state IDLE, owner -> 2'b00.
REQ-023 Latency: req seen in IDLE at edge N, bus_ready=1 in first ACCESS cycle -> ack high in cycle N+2; min 3 cycles per transaction.
REQ-024 Non-owner rdata holds its previous value; non-owner request changes are ignored until IDLE.
REQ-025 A requester dropping req during ACCESS does not abort; transaction completes, ack still issued.
REQ-026 bus_addr/bus_wdata hold last latched values outside ACCESS.

Reset
REQ-027 rst=0 forces immediately: state IDLE, pointer=m0, owner=2'b00, bus_addr=0, bus_wdata=0, bus_we=0, m0/m1_rdata=0, m0/m1_ack=0, err=0, timeout counter=0.
REQ-028 Reset during ACCESS abandons the transaction without any ack; first post-reset arbitration favours m0.

Configuration
REQ-029 Macro MIO_ARB_TIMEOUT_EN defined: counter clears on entry to ACCESS, increments each ACCESS cycle without bus_ready; on reaching TIMEOUT_CYC, owner's rdata=32'hDEAD_BEEF, go ACK, err=1 in the ACK cycle.
REQ-030 bus_ready and timeout in the same cycle -> bus_ready wins (normal completion, err=0).
REQ-031 Macro undefined: ACCESS waits on bus_ready indefinitely; no counter logic; err tied to 0.

Verification
REQ-032 m0 reads 0x0000_0010, bus_ready=1, bus_rdata=0x1234_5678 -> m0_ack 2 cycles after req sampled, m0_rdata=0x1234_5678, bus_we=0 throughout.
REQ-033 m0 and m1 assert req in the same cycle after reset, repeatedly -> grants m0, m1, m0, m1; each ack single-cycle, never both acks high.
REQ-034 m1 writes 0xFFFF_1004 data 0xA5A5_A5A5 -> bus_we=1 only in the single ACCESS cycle, bus_addr=0xFFFF_1004, bus_wdata=0xA5A5_A5A5.
REQ-035 bus_ready held 0, macro defined, TIMEOUT_CYC=16 -> ack + err after 16 ACCESS cycles, rdata=0xDEAD_BEEF; macro undefined -> no ack for 100 cycles, then bus_ready=1 -> normal ack.
REQ-036 rst=0 asserted mid-ACCESS -> all outputs at reset values asynchronously, no ack; after release m0 wins a simultaneous request.

Source files
------------

// File: rtl/mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter
//
// Two-requester round-robin arbiter for the shared memory/IO bus. Requester 0
// is the CPU, requester 1 is the DMA / VRAM refresh engine. Each transaction
// walks IDLE -> ACCESS -> ACK, so the minimum cost is three cycles. Every
// output is driven straight from a flop.
//
// Optional feature:
//   MIO_ARB_TIMEOUT_EN  when defined, an ACCESS that sees no bus_ready for
//                       TIMEOUT_CYC cycles is forced into ACK. The owner then
//                       gets 32'hDEAD_BEEF as read data, and err pulses
//                       together with its ack. When the macro is undefined,
//                       ACCESS waits on bus_ready forever and err is tied to 0.
//
// Parameters
//   TIMEOUT_CYC   ACCESS cycles allowed before forced termination (2..255)
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   m0_req/addr/wdata/we       requester 0 request; held until m0_ack
//   m0_rdata, m0_ack           requester 0 read data and 1-cycle completion
//   m1_*                       requester 1, same semantics as m0_*
//   bus_addr/wdata/we          shared bus drive (bus_we only high in ACCESS)
//   bus_rdata, bus_ready       shared bus return data and completion
//   owner                      2'b00 none, 2'b01 m0, 2'b10 m1
//   err                        timeout flag, pulses with the terminated ack
// -----------------------------------------------------------------------------
module mio_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_we,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready,
   output logic [1:0]  owner,
   output logic        err
);

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("mio_bus_arbiter: TIMEOUT_CYC must lie in 2..255");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;          // 0: m0 preferred, 1: m1 preferred
   logic [1:0]        req;
   logic              gnt_m1;                // winner in IDLE (1 = m1)
   logic              to_hit;                // forced termination this cycle

   logic [1:0]        owner_d;
   logic [31:0]       bus_addr_d, bus_wdata_d;
   logic              bus_we_d;
   logic [1:0][31:0]  rdata_q, rdata_d;
   logic [1:0]        ack_q, ack_d;

   assign req = {m1_req, m0_req};

   // The pointer only matters when both requesters are present; a lone
   // requester always wins.
   assign gnt_m1 = req[1] & (~req[0] | ptr_q);

   // ---------------------------------------------------------------------------
   // Timeout counter
   // ---------------------------------------------------------------------------
`ifdef MIO_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] to_cnt_q;

   // The counter holds the number of ACCESS cycles already spent without
   // bus_ready, so the cycle that would be the TIMEOUT_CYC-th one terminates.
   // A bus_ready in that same cycle still wins.
   assign to_hit = ~bus_ready & (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_q <= 8'd0;
      end else if (state_q == S_IDLE && |req) begin
         to_cnt_q <= 8'd0;
      end else if (state_q == S_ACCESS && !bus_ready && !to_hit) begin
         to_cnt_q <= to_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else begin
         err <= (state_q == S_ACCESS) && to_hit;
      end
   end
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (|req) state_d = S_ACCESS;
         S_ACCESS: if (bus_ready || to_hit) state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. These are next values for the output flops below, so every
   // port changes only on a clock edge.
   // ---------------------------------------------------------------------------
   always_comb begin
      ptr_d       = ptr_q;
      owner_d     = owner;
      bus_addr_d  = bus_addr;
      bus_wdata_d = bus_wdata;
      bus_we_d    = 1'b0;
      rdata_d     = rdata_q;
      ack_d       = 2'b00;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               // The bus address/data flops are the transaction latch. They
               // keep their value after the access ends.
               bus_addr_d  = gnt_m1 ? m1_addr  : m0_addr;
               bus_wdata_d = gnt_m1 ? m1_wdata : m0_wdata;
               bus_we_d    = gnt_m1 ? m1_we    : m0_we;
               owner_d     = gnt_m1 ? 2'b10    : 2'b01;
            end
         end
         S_ACCESS: begin
            if (bus_ready) begin
               rdata_d[owner[1]] = bus_rdata;
               ack_d[owner[1]]   = 1'b1;
               ptr_d             = ~owner[1];
            end else if (to_hit) begin
               rdata_d[owner[1]] = 32'hDEAD_BEEF;
               ack_d[owner[1]]   = 1'b1;
               ptr_d             = ~owner[1];
            end else begin
               // The latched write enable is the bus_we flop itself.
               bus_we_d = bus_we;
            end
         end
         S_ACK: begin
            owner_d = 2'b00;
         end
         default: begin
            owner_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= 1'b0;
         owner     <= 2'b00;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_we    <= 1'b0;
         rdata_q   <= '0;
         ack_q     <= 2'b00;
      end else begin
         ptr_q     <= ptr_d;
         owner     <= owner_d;
         bus_addr  <= bus_addr_d;
         bus_wdata <= bus_wdata_d;
         bus_we    <= bus_we_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
      end
   end

   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign m0_ack   = ack_q[0];
   assign m1_ack   = ack_q[1];

endmodule

// File: tb/tb_mio_bus_arbiter.sv
module tb_mio_bus_arbiter;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
   logic        m0_ack, m1_ack, bus_we, err;
   logic [31:0] bus_rdata = '0;
   logic        bus_ready = 1'b0;
   logic [1:0]  owner;

   always #5 clk = ~clk;

   mio_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .owner(owner), .err(err));

   typedef struct {logic [31:0] addr; logic [31:0] wdata; logic we;} txn_t;
   typedef struct {logic id; logic [31:0] rd0; logic [31:0] rd1; logic err;} ack_exp_t;
   typedef struct {logic [1:0] own; logic [31:0] addr; logic [31:0] wdata; logic we;} bus_exp_t;

   ack_exp_t    exp_ack[$];
   bus_exp_t    exp_bus[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];

   int          n_vec = 0, n_err = 0;
   int          slv_delay = 0;
   int          pref = 0;              // model: requester favoured on a tie
   logic [31:0] rd_m [2];              // model: each requester's rdata

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.addr  = ($urandom_range(0, 1) ? 32'hFFFF_1000 : 32'h0000_1000) + 32'(4 * $urandom_range(0, 7));
      t.wdata = $urandom;
      t.we    = 1'($urandom_range(0, 1));
      return t;
   endfunction

   // Reference model: one granted transaction, in order of service. The slave
   // returns ~wdata on a write, and the owner captures it as its rdata.
   task automatic model_txn(input int id, input txn_t t);
      ack_exp_t a;
      bus_exp_t b;
      b.own = (id == 1) ? 2'b10 : 2'b01;
      b.addr = t.addr; b.wdata = t.wdata; b.we = t.we;
      exp_bus.push_back(b);
      if (t.we) begin
         ref_mem[t.addr] = t.wdata;
         rd_m[id] = ~t.wdata;
      end else begin
         rd_m[id] = ref_rd(t.addr);
      end
      pref = 1 - id;
      a.id = 1'(id); a.rd0 = rd_m[0]; a.rd1 = rd_m[1]; a.err = 1'b0;
      exp_ack.push_back(a);
   endtask

   // Called at a negedge with the DUT idle. pat bit0 = m0 requests, bit1 = m1.
   task automatic run_round(input int pat, input txn_t t0, input txn_t t1, input int d);
      int first, cyc;
      int exp_cyc [2];
      logic [1:0] pend;
      slv_delay = d;
      first = (pat == 3) ? pref : ((pat == 2) ? 1 : 0);
      exp_cyc[first] = 2 + d;
      model_txn(first, first ? t1 : t0);
      if (pat == 3) begin
         exp_cyc[1 - first] = 5 + 2 * d;
         model_txn(1 - first, first ? t0 : t1);
      end
      pend = pat[1:0];
      if (pend[0]) begin m0_addr = t0.addr; m0_wdata = t0.wdata; m0_we = t0.we; m0_req = 1'b1; end
      if (pend[1]) begin m1_addr = t1.addr; m1_wdata = t1.wdata; m1_we = t1.we; m1_req = 1'b1; end
      cyc = 0;
      while (pend != 2'b00 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (pend[0] && m0_ack) begin chk("latency_m0", cyc, exp_cyc[0]); m0_req = 1'b0; pend[0] = 1'b0; end
         if (pend[1] && m1_ack) begin chk("latency_m1", cyc, exp_cyc[1]); m1_req = 1'b0; pend[1] = 1'b0; end
      end
      if (pend != 2'b00) begin
         fail("ack_wait_expired");
         m0_req = 1'b0; m1_req = 1'b0;
         exp_ack.delete(); exp_bus.delete();
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   // Bus slave: answers after slv_delay wait cycles and checks the bus
   // transaction against the model's queue.
   initial begin
      int wcnt;
      bus_exp_t be;
      wcnt = 0;
      forever begin
         @(negedge clk);
         bus_ready = 1'b0;
         bus_rdata = $urandom;
         if (rst && owner != 2'b00 && !m0_ack && !m1_ack) begin
            if (wcnt >= slv_delay) begin
               bus_ready = 1'b1;
               wcnt = 0;
               if (exp_bus.size() == 0) begin
                  fail("unexpected_bus_access");
               end else begin
                  be = exp_bus.pop_front();
                  chk("bus_owner", 32'(owner), 32'(be.own));
                  chk("bus_addr", bus_addr, be.addr);
                  chk("bus_we", 32'(bus_we), 32'(be.we));
                  if (be.we) chk("bus_wdata", bus_wdata, be.wdata);
               end
               if (bus_we) begin
                  slv_mem[bus_addr] = bus_wdata;
                  bus_rdata = ~bus_wdata;
               end else begin
                  bus_rdata = slv_rd(bus_addr);
               end
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Completion monitor: pops the model's expectation on every ack.
   initial begin
      ack_exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (m0_ack && m1_ack) fail("both_acks_high");
            if (m0_ack || m1_ack) begin
               if (exp_ack.size() == 0) begin
                  fail("unexpected_ack");
               end else begin
                  e = exp_ack.pop_front();
                  chk("ack_id", 32'(m1_ack), 32'(e.id));
                  chk("m0_rdata", m0_rdata, e.rd0);
                  chk("m1_rdata", m1_rdata, e.rd1);
                  chk("ack_err", 32'(err), 32'(e.err));
                  chk("ack_bus_we", 32'(bus_we), 32'd0);
                  chk("ack_owner", 32'(owner), e.id ? 32'd2 : 32'd1);
               end
            end else begin
               chk("err_idle", 32'(err), 32'd0);
               if (owner == 2'b00) chk("idle_bus_we", 32'(bus_we), 32'd0);
            end
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_owner"}, 32'(owner), 32'd0);
      chk({tag, "_bus_addr"}, bus_addr, 32'd0);
      chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
      chk({tag, "_bus_we"}, 32'(bus_we), 32'd0);
      chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
      chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
      chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t0, t1;
      ack_exp_t a;
      int cyc;
      logic seen;
      rd_m[0] = '0; rd_m[1] = '0;

      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);

      // Simultaneous requests after reset alternate m0, m1, m0, m1.
      for (int i = 0; i < 2; i++) run_round(3, rand_txn(), rand_txn(), 0);

      // m0 reads 0x10 and the slave returns 0x1234_5678 with no wait.
      ref_mem[32'h10] = 32'h1234_5678;
      slv_mem[32'h10] = 32'h1234_5678;
      t0.addr = 32'h10; t0.wdata = 32'h0; t0.we = 1'b0;
      run_round(1, t0, t0, 0);

      // m1 writes 0xA5A5_A5A5 to 0xFFFF_1004.
      t1.addr = 32'hFFFF_1004; t1.wdata = 32'hA5A5_A5A5; t1.we = 1'b1;
      run_round(2, t1, t1, 0);

      for (int r = 0; r < 150; r++)
         run_round($urandom_range(1, 3), rand_txn(), rand_txn(), $urandom_range(0, 3));

      // A slave that never answers.
      t0.addr = 32'h0000_1008; t0.wdata = 32'h0; t0.we = 1'b0;
      slv_delay = 100000;
`ifdef MIO_ARB_TIMEOUT_EN
      rd_m[0] = 32'hDEAD_BEEF;
      pref = 1;
      a.id = 1'b0; a.rd0 = rd_m[0]; a.rd1 = rd_m[1]; a.err = 1'b1;
      exp_ack.push_back(a);
      m0_addr = t0.addr; m0_we = 1'b0; m0_req = 1'b1;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (m0_ack) seen = 1'b1;
      end
      chk("timeout_latency", cyc, TO + 1);
      m0_req = 1'b0;
`else
      model_txn(0, t0);
      m0_addr = t0.addr; m0_we = 1'b0; m0_req = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (m0_ack) seen = 1'b1;
      end
      chk("no_ack_while_stalled", 32'(seen), 32'd0);
      slv_delay = 0;
      cyc = 0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (m0_ack) seen = 1'b1;
      end
      chk("ack_after_release", 32'(seen), 32'd1);
      m0_req = 1'b0;
`endif
      repeat (2) @(negedge clk);

      // Reset in the middle of an ACCESS. The model pointer is now at m1.
      slv_delay = 100000;
      m0_addr = 32'h0000_1010; m0_we = 1'b0; m0_req = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_reset_owner", 32'(owner), 32'd1);
      #2 rst = 1'b0;
      #1 chk_reset_vals("async_reset");
      @(negedge clk);
      m0_req = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (m0_ack || m1_ack) seen = 1'b1;
      end
      chk("no_ack_across_reset", 32'(seen), 32'd0);
      exp_ack.delete(); exp_bus.delete();
      pref = 0; rd_m[0] = '0; rd_m[1] = '0;
      rst = 1'b1;
      @(negedge clk);
      run_round(3, rand_txn(), rand_txn(), 1);

      repeat (5) @(negedge clk);
      chk("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
      chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
